// File: rtl/tppe_match_scheduler.sv
// tppe_match_scheduler: scans NUM_NEURONS weight patterns against one latched
// input spike pattern and emits a popcount(pattern & weight) score per neuron
// over a valid/ready interface, followed by a one-cycle done pulse per frame.
//
// Optional feature macro: ZERO_SKIP_EN
//   When defined, neurons whose score is zero are not emitted; the scan still
//   visits every neuron and done still pulses once per frame.

// Combinational popcount of the bitwise AND of two spike patterns.
module pattern_matcher #(
  parameter int T_WINDOW = 16,
  parameter int SCORE_W  = $clog2(T_WINDOW + 1)
) (
  input  logic [T_WINDOW-1:0] pattern,
  input  logic [T_WINDOW-1:0] weight,
  output logic [SCORE_W-1:0]  score
);

  logic [T_WINDOW-1:0] overlap;

  assign overlap = pattern & weight;

  // Count coincident spikes; SCORE_W holds T_WINDOW so a full match cannot wrap.
  always_comb begin
    score = '0;
    for (int i = 0; i < T_WINDOW; i++) begin
      score = score + SCORE_W'(overlap[i]);
    end
  end

endmodule

module tppe_match_scheduler #(
  parameter int T_WINDOW    = 16,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  parameter int SCORE_W     = $clog2(T_WINDOW + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [T_WINDOW-1:0] in_pattern,
  output logic                wt_rd_en,
  output logic [IDX_W-1:0]    wt_rd_addr,
  input  logic [T_WINDOW-1:0] wt_rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_idx,
  output logic [SCORE_W-1:0]  out_score,
  output logic                done
);

  // Reject configurations outside the supported neuron count at elaboration.
  generate
    if (NUM_NEURONS < 1 || NUM_NEURONS > 256) begin : g_bad_num_neurons
      $error("tppe_match_scheduler: NUM_NEURONS must be in 1..256");
    end
  endgenerate

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MATCH,
    EMIT,
    DONE
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     index;
  logic [IDX_W-1:0]     next_index;
  logic [T_WINDOW-1:0]  pattern_q;
  logic [SCORE_W-1:0]   match_score;
  logic                 is_last;

  assign next_index = index + 1'b1;
  assign is_last    = (index == LAST_IDX);

  // The weight word returned by memory is only meaningful during MATCH,
  // which is exactly the cycle the score is captured.
  pattern_matcher #(
    .T_WINDOW (T_WINDOW),
    .SCORE_W  (SCORE_W)
  ) u_matcher (
    .pattern (pattern_q),
    .weight  (wt_rd_data),
    .score   (match_score)
  );

  // Frame sequencer: every output is registered and updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      index      <= '0;
      pattern_q  <= '0;
      in_ready   <= 1'b1;
      wt_rd_en   <= 1'b0;
      wt_rd_addr <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_score  <= '0;
      done       <= 1'b0;
    end else begin
      wt_rd_en <= 1'b0;
      done     <= 1'b0;

      case (state)
        IDLE: begin
          if (in_valid) begin
            pattern_q  <= in_pattern;
            index      <= '0;
            in_ready   <= 1'b0;
            wt_rd_en   <= 1'b1;
            wt_rd_addr <= '0;
            state      <= READ;
          end
        end

        READ: begin
          state <= MATCH;
        end

        MATCH: begin
`ifdef ZERO_SKIP_EN
          if (match_score == '0) begin
            if (is_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              index      <= next_index;
              wt_rd_en   <= 1'b1;
              wt_rd_addr <= next_index;
              state      <= READ;
            end
          end else
`endif
          begin
            out_score <= match_score;
            out_idx   <= index;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end

        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (is_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              index      <= next_index;
              wt_rd_en   <= 1'b1;
              wt_rd_addr <= next_index;
              state      <= READ;
            end
          end
        end

        DONE: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
